// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the multi-channel button debouncer.
package debounce_pkg;

    localparam int DB_STABLE_CYCLES_DEF = 20;
    localparam int DB_REPEAT_DELAY_DEF  = 1000000;
    localparam int DB_REPEAT_PERIOD_DEF = 250000;

    // Bits needed to hold values 0 .. value-1, never less than one bit.
    function automatic int db_width(input int value);
        if (value <= 2) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single button channel: 2-flop synchroniser, stability counter, registered
// level, press/release strobes and optional hold-to-repeat strobe.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = DB_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = DB_REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_out,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int CW   = db_width(STABLE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = db_width(RMAX + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

    logic          s1_r;
    logic          s2_r;
    logic          cand_r;
    logic [CW-1:0] cnt_r;
    logic          out_r;
    logic          press_r;
    logic          release_r;
    logic [RW-1:0] rcnt_r;
    logic          repeat_r;

    logic settle_s;
    logic rise_s;
    logic fall_s;

    // The edge on which btn_out takes the candidate value.
    assign settle_s = (s2_r == cand_r) && (cnt_r == CNT_LAST);
    assign rise_s   = settle_s &&  cand_r && !out_r;
    assign fall_s   = settle_s && !cand_r &&  out_r;

    // Synchroniser, stability counter, debounced level and edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r      <= 1'b0;
            s2_r      <= 1'b0;
            cand_r    <= 1'b0;
            cnt_r     <= '0;
            out_r     <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            s1_r      <= btn_in;
            s2_r      <= s1_r;
            press_r   <= rise_s;
            release_r <= fall_s;
            if (s2_r != cand_r) begin
                cand_r <= s2_r;
                cnt_r  <= '0;
            end else if (cnt_r != CNT_LAST) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                out_r <= cand_r;
            end
        end
    end

    // Auto-repeat down-counter; the release edge is excluded so that a
    // repeat strobe can never coincide with btn_release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_r   <= '0;
            repeat_r <= 1'b0;
        end else if (REPEAT_EN == 0) begin
            rcnt_r   <= '0;
            repeat_r <= 1'b0;
        end else if (rise_s) begin
            rcnt_r   <= DELAY_LOAD;
            repeat_r <= 1'b0;
        end else if (out_r && !fall_s) begin
            if (rcnt_r == RW'(0)) begin
                rcnt_r   <= PERIOD_LOAD;
                repeat_r <= 1'b1;
            end else begin
                rcnt_r   <= rcnt_r - RW'(1);
                repeat_r <= 1'b0;
            end
        end else begin
            rcnt_r   <= '0;
            repeat_r <= 1'b0;
        end
    end

    assign btn_out     = out_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;
    assign btn_repeat  = repeat_r;

endmodule

// File: rtl/debounce_multi.sv
// N-channel button conditioner: independent debounce_chan per button bit.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES_DEF,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = DB_REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = DB_REPEAT_PERIOD_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_out,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat
);

    if ((N_CH < 1) || (STABLE_CYCLES < 2) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_param_check
        $fatal(1, "debounce_multi: illegal parameter set");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .REPEAT_EN     (REPEAT_EN),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_in      (btn_in[i]),
            .btn_out     (btn_out[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i]),
            .btn_repeat  (btn_repeat[i])
        );
    end

endmodule
